// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// master: byte source / memory side, slave: the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 5
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_we,
        input  im_addr,
        input  im_wdata
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_we,
        output im_addr,
        output im_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a header byte N and 4*N little-endian data
// bytes, writes N words from address 0 and holds the CPU in reset until done.
//
// state | meaning
// IDLE  | after reset, CPU held, waiting for start
// HDR   | accepting the word-count header byte
// BYTE  | accepting the four bytes of the current word
// WRITE | one-cycle memory write of the assembled word
// DONE  | load finished, CPU released, start reloads
module imem_loader #(
    parameter int ADDR_W = 5
) (
    input  logic             Clock,
    input  logic             Resetn,
    imem_loader_if.slave     bus,
    input  logic             start,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [8:0]       words_loaded
);
    localparam int         DEPTH   = 1 << ADDR_W;
    localparam logic [8:0] DEPTH_C = 9'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_BYTE  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d;
    logic [7:0]  widx_q, widx_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] word_q, word_d;
    logic        err_q, err_d;
    logic [8:0]  wl_q, wl_d;

    logic        in_range;
    logic        xfer;

    // Words past the end of memory are consumed but never written.
    assign in_range = {1'b0, widx_q} < DEPTH_C;

    // All outputs decode registered state only; in_valid/in_data never reach them.
    assign bus.in_ready  = (state_q == S_HDR) || (state_q == S_BYTE);
    assign bus.im_we     = (state_q == S_WRITE) && in_range;
    assign bus.im_addr   = widx_q[ADDR_W-1:0];
    assign bus.im_wdata  = word_q;
    assign cpu_hold      = (state_q != S_DONE);
    assign busy          = (state_q == S_HDR) || (state_q == S_BYTE) || (state_q == S_WRITE);
    assign done          = (state_q == S_DONE);
    assign err           = err_q;
    assign words_loaded  = wl_q;

    assign xfer = bus.in_valid && bus.in_ready;

    // Next-state, byte assembly and word/overflow bookkeeping.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        word_d  = word_q;
        err_d   = err_q;
        wl_d    = wl_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_HDR;
                    err_d   = 1'b0;
                    wl_d    = 9'd0;
                end
            end
            S_HDR: begin
                if (xfer) begin
                    n_d     = bus.in_data;
                    widx_d  = 8'd0;
                    bcnt_d  = 2'd0;
                    state_d = (bus.in_data == 8'd0) ? S_DONE : S_BYTE;
                end
            end
            S_BYTE: begin
                if (xfer) begin
                    word_d[{bcnt_q, 3'b000} +: 8] = bus.in_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (in_range) begin
                    wl_d = wl_q + 9'd1;
                end else begin
                    err_d = 1'b1;
                end
                widx_d  = widx_q + 8'd1;
                // N <= 255 so widx+1 cannot wrap before matching N.
                state_d = ((widx_q + 8'd1) == n_q) ? S_DONE : S_BYTE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset.
    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            widx_q  <= 8'd0;
            bcnt_q  <= 2'd0;
            word_q  <= 32'd0;
            err_q   <= 1'b0;
            wl_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            widx_q  <= widx_d;
            bcnt_q  <= bcnt_d;
            word_q  <= word_d;
            err_q   <= err_d;
            wl_q    <= wl_d;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected memory writes go into a
// scoreboard queue when a stream is built and are popped as im_we pulses.
module tb_imem_loader;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    typedef struct {
        int   n;
        int   gap;
        int   exp_wl;
        logic exp_err;
        int   exp_nowr;
    } vec_t;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       start;
    logic       cpu_hold, busy, done, err;
    logic [8:0] words_loaded;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .bus          (bus),
        .start        (start),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 Clock = ~Clock;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  nowrite_cnt = 0;
    int  gap_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and score any write seen there.
    task automatic tick();
        wr_t e;
        @(negedge Clock);
        cyc++;
        if (bus.im_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %08h, none expected",
                         bus.im_addr, bus.im_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.im_addr), 32'(e.addr));
                chk("wr_data", bus.im_wdata, e.data);
            end
        end
        if (busy === 1'b1 && bus.in_ready === 1'b0 && bus.im_we === 1'b0) nowrite_cnt++;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            bus.in_valid = 1'b0;
            if (i > 0 && bus.in_ready !== 1'b1) gap_bad++;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: in_ready %b after %0d cycles, required 1", bus.in_ready, n);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic send_stream(input bq_t s, input int gap);
        foreach (s[i]) send_byte(s[i], gap);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: done %b after %0d cycles, required 1", done, n);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Little-endian reference assembly of the stream into expected writes.
    task automatic push_words(input bq_t s);
        logic [31:0] d;
        for (int w = 0; w < int'(s[0]); w++) begin
            d = {s[4*w+4], s[4*w+3], s[4*w+2], s[4*w+1]};
            if (w < DEPTH) exp_q.push_back('{addr: ADDR_W'(w), data: d});
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_im_we"}, 32'(bus.im_we), 32'd0);
        chk({tag, "_im_addr"}, 32'(bus.im_addr), 32'd0);
        chk({tag, "_im_wdata"}, bus.im_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        bq_t  s;
        int   c0;

        vecs[0] = '{n: 34, gap: 0, exp_wl: 32, exp_err: 1'b1, exp_nowr: 2};
        vecs[1] = '{n: 0,  gap: 0, exp_wl: 0,  exp_err: 1'b0, exp_nowr: 0};
        vecs[2] = '{n: 1,  gap: 1, exp_wl: 1,  exp_err: 1'b0, exp_nowr: 0};
        vecs[3] = '{n: 5,  gap: 2, exp_wl: 5,  exp_err: 1'b0, exp_nowr: 0};
        vecs[4] = '{n: 32, gap: 0, exp_wl: 32, exp_err: 1'b0, exp_nowr: 0};
        vecs[5] = '{n: 33, gap: 0, exp_wl: 32, exp_err: 1'b1, exp_nowr: 1};

        Resetn       = 1'b1;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) tick();
        chk_reset_vals("rst");
        Resetn = 1'b0;
        tick();

        // Basic two-word load with a continuous source.
        s = '{8'd2, 8'h13, 8'h00, 8'h01, 8'h20, 8'h78, 8'h56, 8'h34, 8'h12};
        exp_q.push_back('{addr: 5'd0, data: 32'h20010013});
        exp_q.push_back('{addr: 5'd1, data: 32'h12345678});
        pulse_start();
        c0 = cyc;
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_hold_during", 32'(cpu_hold), 32'd1);
        chk("t1_in_ready_hdr", 32'(bus.in_ready), 32'd1);
        send_stream(s, 0);
        wait_done(20);
        chk("t1_hold_latency", 32'(cyc - c0), 32'd11);
        chk("t1_words", 32'(words_loaded), 32'd2);
        chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
        chk("t1_err", 32'(err), 32'd0);
        chk("t1_pending", 32'(exp_q.size()), 32'd0);

        // Same stream with three idle cycles before every byte.
        exp_q.push_back('{addr: 5'd0, data: 32'h20010013});
        exp_q.push_back('{addr: 5'd1, data: 32'h12345678});
        gap_bad = 0;
        pulse_start();
        send_stream(s, 3);
        wait_done(20);
        chk("t2_gap_ready", 32'(gap_bad), 32'd0);
        chk("t2_words", 32'(words_loaded), 32'd2);
        chk("t2_pending", 32'(exp_q.size()), 32'd0);

        // Table of load lengths including zero, exact fit and overflow.
        foreach (vecs[v]) begin
            s = {};
            s.push_back(8'(vecs[v].n));
            for (int j = 0; j < 4 * vecs[v].n; j++) s.push_back(8'($urandom));
            push_words(s);
            nowrite_cnt = 0;
            pulse_start();
            send_stream(s, vecs[v].gap);
            if (vecs[v].n == 0) chk("vec_n0_done_next", 32'(done), 32'd1);
            wait_done(20);
            chk("vec_words", 32'(words_loaded), 32'(vecs[v].exp_wl));
            chk("vec_err", 32'(err), 32'(vecs[v].exp_err));
            chk("vec_cpu_hold", 32'(cpu_hold), 32'd0);
            chk("vec_skipped_writes", 32'(nowrite_cnt), 32'(vecs[v].exp_nowr));
            chk("vec_pending", 32'(exp_q.size()), 32'd0);
        end

        // Restart from DONE after an overflowed load clears status.
        pulse_start();
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_err", 32'(err), 32'd0);
        chk("rs_words", 32'(words_loaded), 32'd0);
        chk("rs_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (3) tick();
        chk("rs_wait_hdr_ready", 32'(bus.in_ready), 32'd1);
        chk("rs_wait_hdr_busy", 32'(busy), 32'd1);
        s = '{8'd0};
        send_stream(s, 0);
        wait_done(5);

        // Asynchronous reset in the middle of a word.
        pulse_start();
        s = '{8'd2, 8'h13, 8'h00};
        send_stream(s, 0);
        #2 Resetn = 1'b1;
        #1 chk_reset_vals("arst");
        tick();
        Resetn = 1'b0;
        tick();
        s = '{8'd1, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_q.push_back('{addr: 5'd0, data: 32'hDDCCBBAA});
        pulse_start();
        send_stream(s, 0);
        wait_done(20);
        chk("arst_words", 32'(words_loaded), 32'd1);
        chk("arst_pending", 32'(exp_q.size()), 32'd0);

        // start while receiving bytes is ignored and the word stays intact.
        exp_q.push_back('{addr: 5'd0, data: 32'h44332211});
        pulse_start();
        s = '{8'd1, 8'h11, 8'h22};
        send_stream(s, 0);
        pulse_start();
        chk("sb_busy", 32'(busy), 32'd1);
        chk("sb_in_ready", 32'(bus.in_ready), 32'd1);
        s = '{8'h33, 8'h44};
        send_stream(s, 0);
        wait_done(20);
        chk("sb_words", 32'(words_loaded), 32'd1);
        chk("sb_err", 32'(err), 32'd0);
        chk("sb_pending", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction-memory interface. Receives a byte stream on a valid/ready handshake, assembles little-endian 32-bit words and writes them sequentially into instruction memory from word address 0. Holds the pipelined CPU in reset (`cpu_hold`) until the load completes. Sits between the host/UART byte source and the instruction-memory write port, ahead of the fetch stage.

## Interface
Parameters:
- `ADDR_W`, default 5: instruction-memory word-address width; DEPTH = 2^ADDR_W words.

Ports:
- `Clock`  in  1  system clock; all state changes on the rising edge.
- `Resetn`  in  1  asynchronous, active-high reset. The name follows the codebase's port naming; the polarity is active-high.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- `in_valid`  in  1  byte source has data.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `im_we`  out  1  instruction-memory write enable.
- `im_addr`  out  ADDR_W  word address for the write.
- `im_wdata`  out  32  word to write.
- `cpu_hold`  out  1  1 = keep the CPU in reset.
- `busy`  out  1  load in progress (HDR, BYTE or WRITE).
- `done`  out  1  load finished.
- `err`  out  1  sticky overflow flag.
- `words_loaded`  out  9  count of words actually written.

## Operation
- A byte transfers only on a rising edge where `in_valid & in_ready`.
- Stream format: one header byte N (word count, 0–255), followed by 4·N data bytes. Byte k of each word (k = 0..3) lands in bits [8k+7:8k].
- States:
  - IDLE: `cpu_hold`=1. `start` → HDR.
  - HDR: `in_ready`=1. On transfer, latch N and clear the word index.
    - N = 0 → DONE.
    - Otherwise → BYTE.
  - BYTE: `in_ready`=1. 2-bit byte counter. The 4th accepted byte → WRITE.
  - WRITE (one cycle): `in_ready`=0.
    - `im_we`=1 only if word index < DEPTH.
    - `im_addr` = word index[ADDR_W-1:0]; `im_wdata` = assembled word.
    - Next state: word index+1 = N → DONE; else → BYTE.
  - DONE: `done`=1, `cpu_hold`=0. `start` → HDR, which also clears `done`, `err` and `words_loaded`.
- Overflow: when N > DEPTH, words at index ≥ DEPTH are still consumed but not written (`im_we`=0). `err` sets in the first such WRITE cycle and stays set until the next accepted `start`.
- `words_loaded` increments on every cycle with `im_we`=1, and saturates at DEPTH by construction.
- `start` in HDR, BYTE or WRITE is ignored.
- `start` from IDLE/DONE also clears `err` and `words_loaded`.
- `cpu_hold` = 1 in every state except DONE.
- `busy` = 1 in HDR, BYTE and WRITE.

## Timing
- All outputs are decoded from registered state and counters. There is no combinational path from `in_valid`/`in_data` to any output.
- Reset values: state=IDLE, `in_ready`=0, `im_we`=0, `im_addr`=0, `im_wdata`=0, `cpu_hold`=1, `busy`=0, `done`=0, `err`=0, `words_loaded`=0.
- Reset acts asynchronously at any time. A partial word, the byte counter and the word index are discarded, and `im_we` drops immediately.
- `start` sampled at edge t → HDR from t; `in_ready`=1 during cycle t+1.
- Minimum load time with a continuous source: 1 (HDR) + 5·N cycles (4 BYTE + 1 WRITE per word).
- `im_we` is high for exactly one cycle per word. Memory captures the word on the edge that ends the WRITE cycle.
- `done` and `cpu_hold`=0 appear in the cycle after the last WRITE, or after HDR when N=0.
- `in_valid` low stalls the loader in HDR/BYTE indefinitely with no state change. Stalls between bytes do not corrupt byte order.

## Test plan
- Reset, then `start`; send N=2 and bytes 13 00 01 20, 78 56 34 12 continuously → `im_we` pulses at addr 0 with data 0x20010013 and at addr 1 with data 0x12345678. `words_loaded`=2, `done`=1, `cpu_hold` falls 11 cycles after the HDR edge, `err`=0.
- Same stream, but with `in_valid` deasserted for 3 cycles between every byte → identical writes and data. `in_ready` stays asserted throughout the gaps.
- ADDR_W=5, N=34, 136 bytes → 32 writes at addr 0..31 and 2 WRITE cycles with `im_we`=0. `err`=1, `words_loaded`=32, `done`=1.
- N=0 → no writes; `done`=1 one cycle after the header transfer; `cpu_hold`=0.
- Assert `Resetn` after the 2nd data byte of word 1 → all outputs return to reset values asynchronously. After release and a new load of N=1 with bytes AA BB CC DD, the write is addr 0 with data 0xDDCCBBAA.
- Pulse `start` in BYTE → ignored. `start` in DONE → `done` clears, `err`/`words_loaded` clear, `cpu_hold`=1, and the loader waits in HDR.
